instr_sequencer: RTL and testbench
==================================

// Module: instr_sequencer
// PURPOSE
//  Upstream instruction feeder for `processor`. Stores a small program, holds the processor
//  in reset, then presents one 16-bit instruction on `lin` for HOLD_CYC clocks each, in order.
//  Replaces hand-timed stimulus so programs run on-chip and on the bench the same way.
// PARAMETERS
//  DATA_W    16  instruction width, equal to processor `lin` width
//  ADDR_W    4   program address width; DEPTH = 2**ADDR_W words
//  HOLD_CYC  4   clocks each instruction is held on `lin` (>=1)
//  RST_CYC   2   clocks proc_resetn is held low after start (>=1)
// PORTS
//  clk          in   1       single clock, rising edge
//  resetn       in   1       asynchronous, active-low reset
//  load_en      in   1       program write strobe
//  load_addr    in   ADDR_W  write address
//  load_data    in   DATA_W  instruction word to store
//  last_addr    in   ADDR_W  address of final instruction; sampled on accepted start
//  start        in   1       run request, single-cycle pulse
//  stop         in   1       abort request
//  lin          out  DATA_W  instruction to processor `lin` (registered)
//  proc_resetn  out  1       reset to processor `resetn` (registered, active-low)
//  pc           out  ADDR_W  address of the instruction currently on `lin`
//  busy         out  1       high in RST and RUN
//  done         out  1       high in DONE
// BEHAVIOUR
//  Reset: state=IDLE, lin=0, proc_resetn=0, pc=0, busy=0, done=0, counters 0.
//  FSM IDLE -> RST -> RUN -> DONE; DONE -start-> RST; RST/RUN -stop-> IDLE.
//  Writes: load_en honoured only in IDLE and DONE; ignored in RST and RUN. Write in the same
//   cycle as start is performed, and the new word is fetched.
//  start in IDLE or DONE: latch last_addr, rcnt=0, proc_resetn=0, done=0 -> RST.
//   start in RST or RUN: ignored.
//  RST: rcnt increments each clock. On the edge where rcnt==RST_CYC-1: lin<=mem[0], pc<=0,
//   hcnt<=0, proc_resetn<=1 -> RUN. Reset release and first instruction share one edge.
//  RUN: hcnt increments each clock. On the edge where hcnt==HOLD_CYC-1:
//   - if pc != last_addr: pc<=pc+1, lin<=mem[pc+1], hcnt<=0.
//   - if pc == last_addr: -> DONE. lin keeps the last word and proc_resetn stays 1.
//     Programs therefore end in an idempotent instruction (OUT).
//  pc never wraps in RUN. last_addr=DEPTH-1 ends after the final word.
//   last_addr=0 runs a single instruction.
//  stop in RST or RUN: next edge -> IDLE, lin=0, proc_resetn=0, pc=0.
//   stop wins over completion and start in the same cycle. stop in IDLE or DONE: no effect.
//  Async reset mid-run: immediate return to reset values. Program memory contents undefined.
//  Latency: start edge to first instruction = RST_CYC clocks.
//   Total run = RST_CYC + (last_addr+1)*HOLD_CYC clocks.
// CONFIGURATION
//  SEQ_LOOP_EN defined: on completion, pc<=0, lin<=mem[0], hcnt<=0, stay in RUN.
//   proc_resetn stays 1, done never asserts, and only stop or reset exits.
//  SEQ_LOOP_EN undefined: behaviour as above (-> DONE). Ports are identical in both builds.
// STRUCTURE
//  seq_defs.vh: FSM state codes (IDLE, RST, RUN, DONE).
//   Opcode constants OP_LDI=4'b1010, OP_SUB=4'b0010, OP_OUT=4'b1000, field [15:12].
//  Sub-module prog_mem: DEPTH x DATA_W, synchronous write, asynchronous read, no reset.
//  Top holds FSM, rcnt/hcnt counters and pc.
// TESTING
//  All cases use HOLD_CYC=4 and RST_CYC=2.
//  1 Load A01C,A40A,2080,8000 at 0..3, last_addr=3, start at edge E.
//    -> proc_resetn=0 to E+2; lin=A01C and proc_resetn=1 at E+2; A40A at E+6; 2080 at E+10;
//       8000 at E+14; done=1 at E+18; processor bus shows 18.
//  2 stop at E+7 of case 1 -> at E+8 state IDLE, lin=0, proc_resetn=0, pc=0, busy=0.
//  3 load_en to addr 1 during RUN -> mem unchanged; rerun from DONE replays A40A at E'+6.
//  4 last_addr=0 -> one word for 4 clocks, done at E+6.
//    start during RUN -> ignored; pc sequence unaffected.
//  5 Async resetn low at E+9 -> outputs at reset values immediately;
//    resetn high then start -> normal run.
//  6 SEQ_LOOP_EN, case 1 program -> lin returns to A01C at E+18, done stays 0; stop exits.

Source files
------------

// File: rtl/instr_sequencer_pkg.sv
// Shared FSM state encoding, program opcodes and sizing helper for instr_sequencer.
package instr_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RST  = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } seq_state_t;

    // Opcodes live in instruction bits [15:12].
    localparam logic [3:0] OP_LDI = 4'b1010;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_OUT = 4'b1000;

    // Width of a counter that runs 0..n-1; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/instr_sequencer_prog_mem.sv
// Program store for instr_sequencer: DEPTH x DATA_W, synchronous write, asynchronous read.
module prog_mem #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);
    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];

    // NOTE: storage arrays get no reset; contents are only meaningful after being written.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/instr_sequencer.sv
// Instruction feeder: holds the processor in reset, then plays a stored program on lin.
// Build option SEQ_LOOP_EN: restart from address 0 on completion instead of entering DONE.
module instr_sequencer
    import instr_sequencer_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 4,
    parameter int HOLD_CYC = 4,
    parameter int RST_CYC  = 2
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              load_en,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [DATA_W-1:0] load_data,
    input  logic [ADDR_W-1:0] last_addr,
    input  logic              start,
    input  logic              stop,
    output logic [DATA_W-1:0] lin,
    output logic              proc_resetn,
    output logic [ADDR_W-1:0] pc,
    output logic              busy,
    output logic              done
);
    localparam int RC_W = cnt_width(RST_CYC);
    localparam int HC_W = cnt_width(HOLD_CYC);
    localparam logic [RC_W-1:0] RCNT_LAST = RC_W'(RST_CYC - 1);
    localparam logic [HC_W-1:0] HCNT_LAST = HC_W'(HOLD_CYC - 1);

    seq_state_t        state_q, state_d;
    logic [DATA_W-1:0] lin_q, lin_d;
    logic              proc_resetn_q, proc_resetn_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] last_q, last_d;
    logic [RC_W-1:0]   rcnt_q, rcnt_d;
    logic [HC_W-1:0]   hcnt_q, hcnt_d;

    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              accepting, running, rst_last, hold_last, at_last;

    assign accepting = (state_q == ST_IDLE) || (state_q == ST_DONE);
    assign running   = (state_q == ST_RST)  || (state_q == ST_RUN);
    assign rst_last  = (rcnt_q == RCNT_LAST);
    assign hold_last = (hcnt_q == HCNT_LAST);
    assign at_last   = (pc_q == last_q);

    // Word 0 is fetched during RST and on loop restart; otherwise prefetch pc+1.
    assign rd_addr = ((state_q == ST_RUN) && !at_last) ? pc_q + ADDR_W'(1) : '0;

    prog_mem #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_prog_mem (
        .clk   (clk),
        .we    (load_en && accepting),
        .waddr (load_addr),
        .wdata (load_data),
        .raddr (rd_addr),
        .rdata (rd_data)
    );

    // NOTE: sequential state uses non-blocking assignments and an asynchronous active-low reset.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every signal assigned here gets a default first so no latch is inferred.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_DONE: if (start) state_d = ST_RST;
            ST_RST: begin
                if (stop)          state_d = ST_IDLE;
                else if (rst_last) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (stop) begin
                    state_d = ST_IDLE;
                end else if (hold_last && at_last) begin
`ifdef SEQ_LOOP_EN
                    state_d = ST_RUN;
`else
                    state_d = ST_DONE;
`endif
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        lin_d         = lin_q;
        proc_resetn_d = proc_resetn_q;
        pc_d          = pc_q;
        last_d        = last_q;
        rcnt_d        = rcnt_q;
        hcnt_d        = hcnt_q;
        if (accepting) begin
            if (start) begin
                last_d        = last_addr;
                rcnt_d        = '0;
                proc_resetn_d = 1'b0;
            end
        end else if (running && stop) begin
            // Abort beats completion and any start seen in the same cycle.
            lin_d         = '0;
            proc_resetn_d = 1'b0;
            pc_d          = '0;
            rcnt_d        = '0;
            hcnt_d        = '0;
        end else if (state_q == ST_RST) begin
            if (rst_last) begin
                lin_d         = rd_data;
                pc_d          = '0;
                hcnt_d        = '0;
                rcnt_d        = '0;
                proc_resetn_d = 1'b1;
            end else begin
                rcnt_d = rcnt_q + RC_W'(1);
            end
        end else begin
            if (hold_last) begin
                hcnt_d = '0;
                if (!at_last) begin
                    pc_d  = pc_q + ADDR_W'(1);
                    lin_d = rd_data;
                end
`ifdef SEQ_LOOP_EN
                else begin
                    pc_d  = '0;
                    lin_d = rd_data;
                end
`endif
            end else begin
                hcnt_d = hcnt_q + HC_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            lin_q         <= '0;
            proc_resetn_q <= 1'b0;
            pc_q          <= '0;
            last_q        <= '0;
            rcnt_q        <= '0;
            hcnt_q        <= '0;
        end else begin
            lin_q         <= lin_d;
            proc_resetn_q <= proc_resetn_d;
            pc_q          <= pc_d;
            last_q        <= last_d;
            rcnt_q        <= rcnt_d;
            hcnt_q        <= hcnt_d;
        end
    end

    assign lin         = lin_q;
    assign proc_resetn = proc_resetn_q;
    assign pc          = pc_q;
    assign busy        = running;
    assign done        = (state_q == ST_DONE);

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench for instr_sequencer: scoreboard of expected {lin, pc} per program step.
`timescale 1ns/1ps
module tb_instr_sequencer;
    import instr_sequencer_pkg::*;

    localparam int DATA_W   = 16;
    localparam int ADDR_W   = 4;
    localparam int HOLD_CYC = 4;
    localparam int RST_CYC  = 2;
    localparam int DEPTH    = 16;

    typedef struct {
        logic [DATA_W-1:0] word;
        logic [ADDR_W-1:0] pc;
    } exp_t;

    logic              clk = 1'b0;
    logic              resetn;
    logic              load_en;
    logic [ADDR_W-1:0] load_addr;
    logic [DATA_W-1:0] load_data;
    logic [ADDR_W-1:0] last_addr;
    logic              start;
    logic              stop;
    logic [DATA_W-1:0] lin;
    logic              proc_resetn;
    logic [ADDR_W-1:0] pc;
    logic              busy;
    logic              done;

    exp_t              sb_q[$];
    logic [DATA_W-1:0] model_mem [DEPTH];
    int                n_cmp = 0;
    int                n_bad = 0;

    always #5 clk = ~clk;

    instr_sequencer #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .HOLD_CYC (HOLD_CYC),
        .RST_CYC  (RST_CYC)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .load_en     (load_en),
        .load_addr   (load_addr),
        .load_data   (load_data),
        .last_addr   (last_addr),
        .start       (start),
        .stop        (stop),
        .lin         (lin),
        .proc_resetn (proc_resetn),
        .pc          (pc),
        .busy        (busy),
        .done        (done)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_word(input int addr, input logic [DATA_W-1:0] data);
        load_en   = 1'b1;
        load_addr = ADDR_W'(addr);
        load_data = data;
        tick();
        load_en   = 1'b0;
        model_mem[addr] = data;
    endtask

    task automatic load_case1();
        load_word(0, {OP_LDI, 12'h01C});
        load_word(1, {OP_LDI, 12'h40A});
        load_word(2, {OP_SUB, 12'h080});
        load_word(3, {OP_OUT, 12'h000});
    endtask

    // Pulse start (edge E), optionally writing word 0 in the same cycle, and queue the expected steps.
    task automatic do_start(input int last, input bit wr0, input logic [DATA_W-1:0] wr0_data);
        last_addr = ADDR_W'(last);
        start     = 1'b1;
        if (wr0) begin
            load_en      = 1'b1;
            load_addr    = '0;
            load_data    = wr0_data;
            model_mem[0] = wr0_data;
        end
        tick();
        start     = 1'b0;
        load_en   = 1'b0;
        last_addr = ~ADDR_W'(last);
        for (int i = 0; i <= last; i++) sb_q.push_back('{model_mem[i], ADDR_W'(i)});
    endtask

    // Step through a whole run after do_start; poke 1 = write during RUN, poke 2 = start during RUN.
    task automatic run_check(input string name, input int last, input int poke);
        int   total;
        exp_t e;
        total = RST_CYC + (last + 1) * HOLD_CYC;
        for (int n = 1; n <= total; n++) begin
            tick();
            load_en = 1'b0;
            start   = 1'b0;
            if (n == 1) begin
                n_cmp++;
                if ({proc_resetn, busy, done} !== 3'b010) begin
                    n_bad++;
                    $display("FAIL %s_rst_phase: prn/busy/done=%b required 010", name, {proc_resetn, busy, done});
                end
            end
            if (n >= RST_CYC && n < total && (n - RST_CYC) % HOLD_CYC == 0) begin
                n_cmp++;
                if (sb_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL %s_sb_empty: no expected word at E+%0d", name, n);
                end else begin
                    e = sb_q.pop_front();
                    if ({lin, pc, proc_resetn} !== {e.word, e.pc, 1'b1}) begin
                        n_bad++;
                        $display("FAIL %s_step E+%0d: lin=%h pc=%0d prn=%b required lin=%h pc=%0d prn=1",
                                 name, n, lin, pc, proc_resetn, e.word, e.pc);
                    end
                end
            end
            if (n == total - 1) begin
                n_cmp++;
                if ({busy, done} !== 2'b10) begin
                    n_bad++;
                    $display("FAIL %s_pre_end: busy/done=%b required 10", name, {busy, done});
                end
            end
            if (n == total) begin
`ifdef SEQ_LOOP_EN
                n_cmp++;
                if ({lin, pc, done, busy, proc_resetn} !== {model_mem[0], ADDR_W'(0), 3'b011}) begin
                    n_bad++;
                    $display("FAIL %s_loop: lin=%h pc=%0d done=%b busy=%b prn=%b required lin=%h pc=0 done=0 busy=1 prn=1",
                             name, lin, pc, done, busy, proc_resetn, model_mem[0]);
                end
                stop = 1'b1;
                tick();
                stop = 1'b0;
                n_cmp++;
                if ({lin, proc_resetn, busy} !== '0) begin
                    n_bad++;
                    $display("FAIL %s_loop_stop: lin=%h prn=%b busy=%b required all 0", name, lin, proc_resetn, busy);
                end
`else
                n_cmp++;
                if ({lin, pc, done, busy, proc_resetn} !== {model_mem[last], ADDR_W'(last), 3'b101}) begin
                    n_bad++;
                    $display("FAIL %s_done: lin=%h pc=%0d done=%b busy=%b prn=%b required lin=%h pc=%0d done=1 busy=0 prn=1",
                             name, lin, pc, done, busy, proc_resetn, model_mem[last], last);
                end
`endif
            end
            if (n == 3 && poke == 1) begin
                load_en   = 1'b1;
                load_addr = ADDR_W'(1);
                load_data = 16'hFFFF;
            end
            if (n == 3 && poke == 2) begin
                start     = 1'b1;
                last_addr = '1;
            end
        end
        n_cmp++;
        if (sb_q.size() != 0) begin
            n_bad++;
            $display("FAIL %s_leftover: %0d expected words never shown, required 0", name, sb_q.size());
        end
        sb_q.delete();
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if ({lin, proc_resetn, pc, busy, done} !== '0) begin
            n_bad++;
            $display("FAIL reset_hold: lin=%h prn=%b pc=%0d busy=%b done=%b required all 0", lin, proc_resetn, pc, busy, done);
        end
        resetn = 1'b1;
        tick();
        tick();
        n_cmp++;
        if ({lin, proc_resetn, pc, busy, done} !== '0) begin
            n_bad++;
            $display("FAIL reset_idle: lin=%h prn=%b pc=%0d busy=%b done=%b required all 0", lin, proc_resetn, pc, busy, done);
        end
    endtask

    task automatic test_basic_run();
        load_case1();
        do_start(3, 1'b0, '0);
        run_check("basic", 3, 0);
    endtask

    task automatic test_stop();
        exp_t e;
        do_start(3, 1'b0, '0);
        for (int n = 1; n <= 7; n++) begin
            tick();
            if (n == 2 || n == 6) begin
                e = sb_q.pop_front();
                n_cmp++;
                if ({lin, pc} !== {e.word, e.pc}) begin
                    n_bad++;
                    $display("FAIL stop_pre E+%0d: lin=%h pc=%0d required lin=%h pc=%0d", n, lin, pc, e.word, e.pc);
                end
            end
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        n_cmp++;
        if ({lin, proc_resetn, pc, busy, done} !== '0) begin
            n_bad++;
            $display("FAIL stop_abort: lin=%h prn=%b pc=%0d busy=%b done=%b required all 0", lin, proc_resetn, pc, busy, done);
        end
        sb_q.delete();
    endtask

    task automatic test_load_in_run();
        do_start(3, 1'b0, '0);
        run_check("load_in_run", 3, 1);
        do_start(3, 1'b0, '0);
        run_check("rerun", 3, 0);
    endtask

    task automatic test_single_word();
        do_start(0, 1'b1, {OP_OUT, 12'h001});
        run_check("single", 0, 2);
    endtask

    task automatic test_stop_wins();
        exp_t e;
        do_start(0, 1'b0, '0);
        for (int n = 1; n <= 5; n++) begin
            tick();
            if (n == 2) begin
                e = sb_q.pop_front();
                n_cmp++;
                if ({lin, pc} !== {e.word, e.pc}) begin
                    n_bad++;
                    $display("FAIL stop_wins_word: lin=%h pc=%0d required lin=%h pc=%0d", lin, pc, e.word, e.pc);
                end
            end
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        n_cmp++;
        if ({lin, proc_resetn, busy, done} !== '0) begin
            n_bad++;
            $display("FAIL stop_wins: lin=%h prn=%b busy=%b done=%b required all 0", lin, proc_resetn, busy, done);
        end
        sb_q.delete();
    endtask

    task automatic test_full_depth();
        for (int i = 0; i < DEPTH; i++) begin
            load_word(i, (i == DEPTH - 1) ? {OP_OUT, 12'h0FF} : {OP_SUB, 8'h00, 4'(i)});
        end
        do_start(DEPTH - 1, 1'b0, '0);
        run_check("full_depth", DEPTH - 1, 0);
    endtask

    task automatic test_async_reset();
        exp_t e;
        load_case1();
        do_start(3, 1'b0, '0);
        for (int n = 1; n <= 9; n++) begin
            tick();
            if (n == 2 || n == 6) begin
                e = sb_q.pop_front();
                n_cmp++;
                if ({lin, pc} !== {e.word, e.pc}) begin
                    n_bad++;
                    $display("FAIL arst_pre E+%0d: lin=%h pc=%0d required lin=%h pc=%0d", n, lin, pc, e.word, e.pc);
                end
            end
        end
        #2 resetn = 1'b0;
        #1;
        n_cmp++;
        if ({lin, proc_resetn, pc, busy, done} !== '0) begin
            n_bad++;
            $display("FAIL arst_immediate: lin=%h prn=%b pc=%0d busy=%b done=%b required all 0", lin, proc_resetn, pc, busy, done);
        end
        sb_q.delete();
        #2 resetn = 1'b1;
        tick();
        load_case1();
        do_start(3, 1'b0, '0);
        run_check("post_reset", 3, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached before summary");
        $fatal(1, "watchdog expired");
    end

    initial begin
        resetn    = 1'b0;
        load_en   = 1'b0;
        load_addr = '0;
        load_data = '0;
        last_addr = '0;
        start     = 1'b0;
        stop      = 1'b0;
        test_reset();
        test_basic_run();
        test_stop();
        test_load_in_run();
        test_single_word();
        test_stop_wins();
        test_full_depth();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
